// File: rtl/fft_frame_feeder.sv
// Ping-pong frame collector in front of the radix-4 FFT core: fills N-sample frames,
// launches the FFT per frame, captures the returned bins and flags overrun/hang.
module fft_frame_feeder #(
    parameter int WIDTH   = 12,
    parameter int N       = 16,
    parameter int TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] sample_in,
    input  logic             sample_valid,
    output logic             fft_start,
    input  logic             fft_done,
    output logic [WIDTH-1:0] time_samples [0:N-1],
    input  logic [WIDTH-1:0] freq_samples [0:N-1],
    output logic [WIDTH-1:0] frame_out    [0:N-1],
    output logic             frame_valid,
    output logic             fft_busy,
    output logic             overrun,
    output logic             fft_timeout
);

    localparam int CW = $clog2(N);
    localparam int BW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_BUSY  = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_nx_s;
    logic             wr_bank_r;
    logic             rd_bank_r;
    logic [CW-1:0]    wr_cnt_r;
    logic             pending_r;
    logic             done_q_r;
    logic [BW-1:0]    busy_cnt_r;
    logic             fft_start_r;
    logic             fft_busy_r;
    logic             frame_valid_r;
    logic             overrun_r;
    logic             fft_timeout_r;
    logic [WIDTH-1:0] bank_r      [0:1][0:N-1];
    logic [WIDTH-1:0] frame_out_r [0:N-1];

    logic write_s;
    logic complete_s;
    logic drop_s;
    logic rise_s;
    logic capture_s;
    logic timeout_s;
    logic exit_s;
    logic launch_s;

    // Write-side, capture and launch decisions for the current cycle.
    always_comb begin
        write_s    = sample_valid & ~pending_r;
        complete_s = write_s & (wr_cnt_r == CW'(N - 1));
        drop_s     = sample_valid & pending_r;
        rise_s     = fft_done & ~done_q_r;
        capture_s  = (state_r == ST_BUSY) & rise_s;
        // A capture on the final budget cycle wins over the timeout.
        timeout_s  = (state_r == ST_BUSY) & ~rise_s & (busy_cnt_r == BW'(TIMEOUT - 1));
        exit_s     = capture_s | timeout_s;
        launch_s   = (complete_s & ((state_r == ST_IDLE) | exit_s)) | (pending_r & exit_s);
    end

    // FSM next-state logic.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (launch_s) state_nx_s = ST_START;
                else          state_nx_s = ST_IDLE;
            end
            ST_START: state_nx_s = ST_BUSY;
            ST_BUSY: begin
                if (exit_s) state_nx_s = launch_s ? ST_START : ST_IDLE;
                else        state_nx_s = ST_BUSY;
            end
            default: state_nx_s = ST_IDLE;
        endcase
    end

    // State, bank pointers, counters and registered status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r       <= ST_IDLE;
            wr_bank_r     <= 1'b0;
            rd_bank_r     <= 1'b1;
            wr_cnt_r      <= {CW{1'b0}};
            pending_r     <= 1'b0;
            done_q_r      <= 1'b0;
            busy_cnt_r    <= {BW{1'b0}};
            fft_start_r   <= 1'b0;
            fft_busy_r    <= 1'b0;
            frame_valid_r <= 1'b0;
            overrun_r     <= 1'b0;
            fft_timeout_r <= 1'b0;
        end else begin
            state_r       <= state_nx_s;
            done_q_r      <= fft_done;
            fft_start_r   <= (state_nx_s == ST_START);
            fft_busy_r    <= (state_nx_s != ST_IDLE);
            frame_valid_r <= capture_s;
            if (launch_s) begin
                rd_bank_r <= wr_bank_r;
                wr_bank_r <= ~wr_bank_r;
                wr_cnt_r  <= {CW{1'b0}};
                pending_r <= 1'b0;
            end else if (complete_s) begin
                pending_r <= 1'b1;
            end else if (write_s) begin
                wr_cnt_r  <= wr_cnt_r + CW'(1);
            end else begin
                wr_cnt_r  <= wr_cnt_r;
            end
            if ((state_r == ST_BUSY) && !exit_s) busy_cnt_r <= busy_cnt_r + BW'(1);
            else                                 busy_cnt_r <= {BW{1'b0}};
            if (drop_s)    overrun_r     <= 1'b1;
            else           overrun_r     <= overrun_r;
            if (timeout_s) fft_timeout_r <= 1'b1;
            else           fft_timeout_r <= fft_timeout_r;
        end
    end

    // Sample banks; the bank being filled freezes while a frame is pending.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int b = 0; b < 2; b++) begin
                for (int i = 0; i < N; i++) begin
                    bank_r[b][i] <= {WIDTH{1'b0}};
                end
            end
        end else if (write_s) begin
            bank_r[wr_bank_r][wr_cnt_r] <= sample_in;
        end else begin
            bank_r[wr_bank_r][wr_cnt_r] <= bank_r[wr_bank_r][wr_cnt_r];
        end
    end

    // Held copy of the most recently captured bins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                frame_out_r[i] <= {WIDTH{1'b0}};
            end
        end else if (capture_s) begin
            for (int i = 0; i < N; i++) begin
                frame_out_r[i] <= freq_samples[i];
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                frame_out_r[i] <= frame_out_r[i];
            end
        end
    end

    // Read bank presented to the FFT.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            time_samples[i] = bank_r[rd_bank_r][i];
            frame_out[i]    = frame_out_r[i];
        end
    end

    assign fft_start   = fft_start_r;
    assign fft_busy    = fft_busy_r;
    assign frame_valid = frame_valid_r;
    assign overrun     = overrun_r;
    assign fft_timeout = fft_timeout_r;

endmodule
